// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Purpose  : Program counter with sequential/branch/JAL/JALR update, link
//            value, update counter and optional misaligned-target trapping
//            (enabled by defining PC_UNIT_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_we,
  input  logic [1:0]      pc_sel,
  input  logic            take,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            mret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_prev,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            trap,
  output logic [31:0]     upd_cnt
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_TRAPPED = 1'b1
  } state_t;

  localparam logic [1:0]      c_SEL_SEQ  = 2'b00;
  localparam logic [1:0]      c_SEL_BR   = 2'b01;
  localparam logic [1:0]      c_SEL_JAL  = 2'b10;
  localparam logic [XLEN-1:0] c_FOUR     = XLEN'(4);
  localparam logic [XLEN-1:0] c_BIT0_CLR = ~XLEN'(1);

  state_t            r_state;
  state_t            w_next_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_pc_prev;
  logic [31:0]       r_cnt;
  logic              r_trap;
  logic [XLEN-1:0]   w_pc_plus4;
  logic [XLEN-1:0]   w_pc_imm;
  logic [XLEN-1:0]   w_jalr;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_next_pc;
  logic              w_misaligned;
  logic              w_take_trap;

  // Offsets are two's complement, so a plain modulo-2^XLEN add covers negative imm.
  assign w_pc_plus4   = r_pc + c_FOUR;
  assign w_pc_imm     = r_pc + imm;
  assign w_jalr       = (rs1 + imm) & c_BIT0_CLR;
  assign w_misaligned = |w_target[1:0];

  always_comb begin
    w_target = w_pc_plus4;
    case (pc_sel)
      c_SEL_SEQ: w_target = w_pc_plus4;
      c_SEL_BR:  w_target = take ? w_pc_imm : w_pc_plus4;
      c_SEL_JAL: w_target = w_pc_imm;
      default:   w_target = w_jalr;
    endcase
  end

`ifdef PC_UNIT_TRAP_EN
  logic [XLEN-1:0] r_epc;

  always_comb begin
    w_next_pc    = r_pc;
    w_next_state = r_state;
    w_take_trap  = 1'b0;
    if (pc_we) begin
      if (mret) begin
        w_next_pc    = r_epc;
        w_next_state = ST_RUN;
      end else if (w_misaligned) begin
        w_next_pc    = TRAP_VEC;
        w_take_trap  = 1'b1;
        w_next_state = ST_TRAPPED;
      end else begin
        w_next_pc    = w_target;
      end
    end
  end

  // A trap taken while already trapped simply overwrites epc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_epc <= '0;
    end else if (w_take_trap) begin
      r_epc <= r_pc;
    end
  end

  assign epc = r_epc;
`else
  always_comb begin
    w_next_pc    = r_pc;
    w_next_state = r_state;
    w_take_trap  = 1'b0;
    if (pc_we) begin
      w_next_pc = {w_target[XLEN-1:2], 2'b00};
    end
  end

  assign epc = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_VEC;
      r_pc_prev <= '0;
      r_cnt     <= '0;
      r_trap    <= 1'b0;
    end else begin
      r_trap <= w_take_trap;
      if (pc_we) begin
        r_pc      <= w_next_pc;
        r_pc_prev <= r_pc;
        r_cnt     <= r_cnt + 32'd1;
      end
    end
  end

  // mret and the misalignment flag are consumed only by the trapping build.
  logic w_unused;
  assign w_unused = &{1'b0, mret, w_misaligned};

  assign pc       = r_pc;
  assign pc_prev  = r_pc_prev;
  assign pc_plus4 = w_pc_plus4;
  assign trap     = r_trap;
  assign upd_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Self-checking bench for pc_unit: vector table plus scoreboard,
//            with hand sequences for reset, hold and misaligned targets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_we = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic        take = 1'b0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic        mret = 1'b0;
  logic [31:0] pc, pc_prev, pc_plus4, epc, upd_cnt;
  logic        trap;

  pc_unit #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .pc_we(pc_we), .pc_sel(pc_sel), .take(take),
    .imm(imm), .rs1(rs1), .mret(mret), .pc(pc), .pc_prev(pc_prev),
    .pc_plus4(pc_plus4), .epc(epc), .trap(trap), .upd_cnt(upd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start;
    logic [1:0]  sel;
    logic        tk;
    logic [31:0] im;
    logic [31:0] r1;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] prev;
    logic [31:0] cnt;
    logic        trap;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] pc_m = 32'h0;
  logic [31:0] cnt_m = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".pc"}, pc, e.pc);
      chk({e.name, ".pc_prev"}, pc_prev, e.prev);
      chk({e.name, ".upd_cnt"}, upd_cnt, e.cnt);
      chk({e.name, ".trap"}, {31'b0, trap}, {31'b0, e.trap});
    end
  endtask

  // One accepted update: drive at negedge, push expectation, check after the edge.
  task automatic update(input logic [1:0] sel, input logic tk, input logic [31:0] im,
                        input logic [31:0] r1, input logic mr, input logic [31:0] exp_pc,
                        input logic exp_trap, input string name);
    exp_t e;
    @(negedge clk);
    pc_sel = sel; take = tk; imm = im; rs1 = r1; mret = mr; pc_we = 1'b1;
    e.pc = exp_pc; e.prev = pc_m; e.cnt = cnt_m + 32'd1; e.trap = exp_trap; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pc_we = 1'b0;
    mret  = 1'b0;
    pc_m  = exp_pc;
    cnt_m = cnt_m + 32'd1;
    pop_check();
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0040, 2'b01, 1'b1, 32'hFFFF_FFF8, 32'h0,         32'h0000_0038};
    vecs[1] = '{32'h0000_0040, 2'b01, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0000_0044};
    vecs[2] = '{32'h0000_0010, 2'b11, 1'b0, 32'h0000_0003, 32'h0000_0101, 32'h0000_0104};
    vecs[3] = '{32'hFFFF_FFFC, 2'b00, 1'b0, 32'h0,         32'h0,         32'h0000_0000};
    vecs[4] = '{32'h0000_0100, 2'b10, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_0120};
    vecs[5] = '{32'h0000_0008, 2'b10, 1'b1, 32'hFFFF_FFF0, 32'h0,         32'hFFFF_FFF8};
    vecs[6] = '{32'h0000_0200, 2'b11, 1'b1, 32'hFFFF_FFFC, 32'h0000_1000, 32'h0000_0FFC};

    // Reset state while held
    #12;
    chk("rst.pc", pc, 32'h0);
    chk("rst.pc_prev", pc_prev, 32'h0);
    chk("rst.epc", epc, 32'h0);
    chk("rst.upd_cnt", upd_cnt, 32'h0);
    chk("rst.trap", {31'b0, trap}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Three sequential steps
    update(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4, 1'b0, "seq1");
    update(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'h8, 1'b0, "seq2");
    update(2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 32'hC, 1'b0, "seq3");

    // Hold with pc_we low; a stray mret must be ignored
    @(negedge clk);
    pc_sel = 2'b10; imm = 32'h8; mret = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mret = 1'b0;
    chk("hold.pc", pc, 32'hC);
    chk("hold.pc_prev", pc_prev, 32'h8);
    chk("hold.upd_cnt", upd_cnt, 32'd3);
    chk("hold.trap", {31'b0, trap}, 32'h0);

    // Vector table: set pc with an aligned JALR, then apply the operation
    for (int i = 0; i < 7; i++) begin
      update(2'b11, 1'b0, 32'h0, vecs[i].start, 1'b0, vecs[i].start, 1'b0, $sformatf("setup%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d.pc_plus4", i), pc_plus4, vecs[i].start + 32'd4);
      update(vecs[i].sel, vecs[i].tk, vecs[i].im, vecs[i].r1, 1'b0, vecs[i].exp_pc, 1'b0,
             $sformatf("vec%0d", i));
    end

    // Misaligned JAL target from 0x20
    update(2'b11, 1'b0, 32'h0, 32'h20, 1'b0, 32'h20, 1'b0, "mis.setup");
`ifdef PC_UNIT_TRAP_EN
    update(2'b10, 1'b0, 32'h6, 32'h0, 1'b0, 32'h100, 1'b1, "mis.trap");
    chk("mis.epc", epc, 32'h20);
    @(posedge clk);
    #1;
    chk("mis.trap_pulse_end", {31'b0, trap}, 32'h0);
    update(2'b10, 1'b0, 32'h6, 32'h0, 1'b1, 32'h20, 1'b0, "mis.mret");
    chk("mis.epc_hold", epc, 32'h20);
`else
    update(2'b10, 1'b0, 32'h6, 32'h0, 1'b0, 32'h24, 1'b0, "mis.force");
    chk("mis.epc", epc, 32'h0);
    update(2'b10, 1'b0, 32'h8, 32'h0, 1'b1, 32'h2C, 1'b0, "mis.mret_ignored");
`endif

    // Asynchronous reset mid-cycle while an update is pending
    @(negedge clk);
    pc_sel = 2'b00; take = 1'b0; imm = '0; pc_we = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst.pc", pc, 32'h0);
    chk("arst.upd_cnt", upd_cnt, 32'h0);
    chk("arst.pc_prev", pc_prev, 32'h0);
    @(posedge clk);
    #1;
    chk("arst.pc_after_edge", pc, 32'h0);
    pc_m  = 32'h0;
    cnt_m = 32'h0;

    // First edge after release with pc_we already high is accepted
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{32'h4, 32'h0, 32'h1, 1'b0, "first"});
    @(posedge clk);
    #1;
    pc_we = 1'b0;
    pc_m  = 32'h4;
    cnt_m = 32'h1;
    pop_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
